// File: rtl/read_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ requesters.
// Serves one outstanding read at a time; a watchdog aborts reads that never see r_rdy.
module read_arbiter #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]  req_addr,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [WORD_SIZE-1:0]             rsp_data,
  output logic                             rsp_err,
  output logic                             busy,
  output logic                             r_en,
  output logic [ADDRESS_SIZE-1:0]          r_addr,
  input  logic [WORD_SIZE-1:0]             r_data,
  input  logic                             r_rdy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [7:0]              wd_reg, wd_next;
  logic [NUM_REQ-1:0]      grant_reg, grant_next;
  logic [NUM_REQ-1:0]      rsp_valid_reg, rsp_valid_next;
  logic [WORD_SIZE-1:0]    rsp_data_reg, rsp_data_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic                    busy_reg, busy_next;
  logic                    r_en_reg, r_en_next;
  logic [ADDRESS_SIZE-1:0] r_addr_reg, r_addr_next;

  logic [ADDRESS_SIZE-1:0] addr_arr [NUM_REQ];
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W:0]          sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDRESS_SIZE +: ADDRESS_SIZE];
    end
  endgenerate

  // Scan offsets from the far end so the requester nearest ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ))
        sum = sum - (IDX_W+1)'(NUM_REQ);
      if (req[sum[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    idx_next       = idx_reg;
    wd_next        = wd_reg;
    grant_next     = grant_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    busy_next      = busy_reg;
    r_en_next      = r_en_reg;
    r_addr_next    = r_addr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          grant_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
          idx_next    = sel_idx;
          r_addr_next = addr_arr[sel_idx];
          r_en_next   = 1'b1;
          busy_next   = 1'b1;
          wd_next     = '0;
          state_next  = READ;
        end
      end
      READ: begin
        // A data acknowledge wins over watchdog expiry in the same cycle.
        if (r_en_reg && r_rdy) begin
          rsp_data_next  = r_data;
          rsp_valid_next = grant_reg;
          rsp_err_next   = 1'b0;
          r_en_next      = 1'b0;
          state_next     = RESP;
        end else if (wd_reg == 8'(TIMEOUT - 1)) begin
          rsp_data_next  = '0;
          rsp_valid_next = grant_reg;
          rsp_err_next   = 1'b1;
          r_en_next      = 1'b0;
          state_next     = RESP;
        end else begin
          wd_next = wd_reg + 8'd1;
        end
      end
      RESP: begin
        rsp_valid_next = '0;
        rsp_err_next   = 1'b0;
        grant_next     = '0;
        busy_next      = 1'b0;
        ptr_next       = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      idx_reg       <= '0;
      wd_reg        <= '0;
      grant_reg     <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      r_en_reg      <= 1'b0;
      r_addr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      idx_reg       <= idx_next;
      wd_reg        <= wd_next;
      grant_reg     <= grant_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      busy_reg      <= busy_next;
      r_en_reg      <= r_en_next;
      r_addr_reg    <= r_addr_next;
    end
  end

  assign grant     = grant_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = busy_reg;
  assign r_en      = r_en_reg;
  assign r_addr    = r_addr_reg;

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter: single read, round-robin, wait states, timeout, reset.
// The memory model returns {~addr, addr} for every address.
module tb_read_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [3:0]  grant;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        r_en;
  logic [3:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_rdy;

  int checks = 0;
  int errors = 0;

  read_arbiter #(
    .WORD_SIZE(8), .ADDRESS_SIZE(4), .NUM_REQ(4), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_rdy(r_rdy)
  );

  always #5 clock = ~clock;

  assign r_data = {~r_addr, r_addr};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
  logic [7:0]  word  [4] = '{8'h3C, 8'hC3, 8'h96, 8'h69};

  initial begin
    reset_n  = 1'b0;
    req      = 4'b0000;
    req_addr = 16'h953C;
    r_rdy    = 1'b0;
    step();
    step();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_r_en", 32'(r_en), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_r_addr", 32'(r_addr), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    reset_n = 1'b1;
    step();
    chk("idle_no_req_r_en", 32'(r_en), 32'h0);

    // Single requester 2, address 5, memory word 0xA5
    req = 4'b0100;
    step();
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_r_en", 32'(r_en), 32'h1);
    chk("single_r_addr", 32'(r_addr), 32'h5);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
    r_rdy = 1'b1;
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_data", 32'(rsp_data), 32'hA5);
    chk("single_rsp_err", 32'(rsp_err), 32'h0);
    chk("single_r_en_drop", 32'(r_en), 32'h0);
    req   = 4'b0000;
    r_rdy = 1'b0;
    step();
    chk("single_rsp_pulse_end", 32'(rsp_valid), 32'h0);
    chk("single_grant_clear", 32'(grant), 32'h0);
    chk("single_busy_clear", 32'(busy), 32'h0);

    // All four requesting, zero-wait memory; ptr starts at 3
    req_addr = 16'h963C;
    req      = 4'b1111;
    r_rdy    = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("rr%0d_grant", n), 32'(grant), 32'(1 << order[n]));
      chk($sformatf("rr%0d_r_en", n), 32'(r_en), 32'h1);
      step();
      chk($sformatf("rr%0d_rsp_valid", n), 32'(rsp_valid), 32'(1 << order[n]));
      chk($sformatf("rr%0d_rsp_data", n), 32'(rsp_data), 32'(word[order[n]]));
      step();
      chk($sformatf("rr%0d_rsp_end", n), 32'(rsp_valid), 32'h0);
    end
    req   = 4'b0000;
    r_rdy = 1'b0;

    // Wait states on requester 1 (ptr=3 -> 1 is the only requester)
    req = 4'b0010;
    step();
    chk("ws_grant", 32'(grant), 32'h2);
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("ws%0d_r_en", i), 32'(r_en), 32'h1);
      chk($sformatf("ws%0d_r_addr", i), 32'(r_addr), 32'h3);
      chk($sformatf("ws%0d_grant", i), 32'(grant), 32'h2);
      chk($sformatf("ws%0d_no_rsp", i), 32'(rsp_valid), 32'h0);
    end
    r_rdy = 1'b1;
    step();
    chk("ws_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("ws_rsp_data", 32'(rsp_data), 32'hC3);
    req   = 4'b0000;
    r_rdy = 1'b0;
    step();

    // Timeout: ptr=2, requesters 0 and 3 pending, 3 wins
    req = 4'b1001;
    step();
    chk("to_grant", 32'(grant), 32'h8);
    chk("to_r_addr", 32'(r_addr), 32'h9);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("to%0d_no_rsp", i), 32'(rsp_valid), 32'h0);
    end
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_data", 32'(rsp_data), 32'h0);
    chk("to_r_en_drop", 32'(r_en), 32'h0);
    req = 4'b0001;
    step();
    chk("to_rsp_end", 32'(rsp_valid), 32'h0);
    chk("to_err_end", 32'(rsp_err), 32'h0);
    step();
    chk("to_next_grant", 32'(grant), 32'h1);

    // r_rdy arrives on the same edge the watchdog expires
    for (int i = 0; i < 7; i++) step();
    chk("tie_still_reading", 32'(r_en), 32'h1);
    r_rdy = 1'b1;
    step();
    chk("tie_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tie_rsp_err", 32'(rsp_err), 32'h0);
    chk("tie_rsp_data", 32'(rsp_data), 32'h3C);
    req   = 4'b0000;
    r_rdy = 1'b0;
    step();

    // Reset mid-READ; ptr is 1 before reset and must return to 0
    req = 4'b0100;
    step();
    chk("mr_grant", 32'(grant), 32'h4);
    step();
    reset_n = 1'b0;
    #1;
    chk("mr_grant_zero", 32'(grant), 32'h0);
    chk("mr_r_en_zero", 32'(r_en), 32'h0);
    chk("mr_busy_zero", 32'(busy), 32'h0);
    chk("mr_r_addr_zero", 32'(r_addr), 32'h0);
    r_rdy = 1'b1;
    step();
    chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
    reset_n = 1'b1;
    req     = 4'b1111;
    step();
    chk("mr_restart_grant", 32'(grant), 32'h1);
    step();
    chk("mr_restart_rsp", 32'(rsp_valid), 32'h1);
    chk("mr_restart_data", 32'(rsp_data), 32'h3C);
    req   = 4'b0000;
    r_rdy = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_arbiter.md
# read_arbiter

Round-robin arbiter that shares one memory read port (r_en / r_addr / r_data / r_rdy handshake) among up to NUM_REQ independent requesters, such as several sequencers playing from one pattern memory. It serialises requests, drives the shared port with one outstanding read at a time, and returns the data word to the winning requester with a one-cycle valid pulse. A watchdog aborts reads that the memory never acknowledges, so one stalled access cannot lock out the other requesters.

## Interface
- WORD_SIZE, 8, data word width
- ADDRESS_SIZE, 4, memory address width
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, maximum cycles waiting for r_rdy before abort (1..255)
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester read request, level, held until its rsp_valid bit
- req_addr  in  NUM_REQ*ADDRESS_SIZE  packed addresses; requester i uses bits [i*ADDRESS_SIZE +: ADDRESS_SIZE], stable while req[i]
- grant  out  NUM_REQ  one-hot; the requester currently owning the port, 0 when idle
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse; completion for that requester
- rsp_data  out  WORD_SIZE  read data; valid only with rsp_valid
- rsp_err  out  1  high with rsp_valid when the read timed out (rsp_data then 0)
- busy  out  1  high in READ or RESP
- r_en  out  1  memory read enable
- r_addr  out  ADDRESS_SIZE  memory read address
- r_data  in  WORD_SIZE  memory read data, valid in a cycle with r_en & r_rdy
- r_rdy  in  1  memory acknowledge

## Operation
- All outputs are registered. Reset values: grant=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, r_en=0, r_addr=0. Internal state is IDLE, priority pointer ptr=0, watchdog count=0.
- FSM has three states: IDLE, READ and RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching ptr, ptr+1, …, NUM_REQ-1, 0, … (wrap-around).
  - On selection, register grant to that one-hot bit, r_addr to that requester's address, r_en=1, busy=1, clear the watchdog, and go to READ.
  - If no req bit is set, hold all outputs.
- READ:
  - r_en and r_addr stay stable.
  - If r_en & r_rdy: register rsp_data=r_data, rsp_valid=grant, rsp_err=0, r_en=0, and go to RESP.
  - Otherwise, if the watchdog equals TIMEOUT-1: register rsp_valid=grant, rsp_err=1, rsp_data=0, r_en=0, and go to RESP.
  - Otherwise, increment the watchdog.
  - r_rdy has priority over timeout in the same cycle.
- RESP:
  - Clear rsp_valid and rsp_err, clear grant, busy=0, set ptr=(granted index+1) mod NUM_REQ, and go to IDLE.
  - req is ignored in this state. The requester must drop req in response to rsp_valid; a requester that keeps req high is served again, under round-robin fairness.
- Changes to req or req_addr for a non-granted requester while busy have no effect. Dropping req[i] for the granted requester mid-READ does not cancel the read; the response pulse is still issued.
- r_rdy while r_en=0 is ignored.
- Asserting reset_n low at any point, including mid-READ, returns all outputs to reset values at once; any in-flight read is discarded without a response.

## Timing
- Request sampled at edge 0 → r_en, grant and r_addr are high/valid after edge 1.
- r_rdy sampled high at edge k → rsp_valid and rsp_data are high/valid after edge k+1 for exactly one cycle. FSM is in IDLE after edge k+2, and the next r_en can rise after edge k+3.
- Zero-wait memory (r_rdy tied high): 3 cycles per read, one new read issued every 3 cycles.
- Timeout: with r_en high from edge 1, the abort response appears after edge TIMEOUT+1.
- Fairness: with all NUM_REQ requesters continuously requesting, each is served exactly once per NUM_REQ reads.

## Test plan
- Reset, then single requester: req[2]=1, addr 5, r_rdy high the cycle after r_en, r_data=0xA5 → r_addr=5 and grant=0b0100 from cycle 1; rsp_valid=0b0100 and rsp_data=0xA5 in cycle 2 only, rsp_err=0.
- All four requesting continuously, r_rdy tied high → grant order 0,1,2,3,0,1…, one rsp_valid every 3 cycles, the correct word returned to each requester.
- Wait states: r_rdy low for 10 cycles after r_en → r_en and r_addr stable throughout; rsp_valid follows one cycle after r_rdy; other req bits are ignored meanwhile.
- Timeout with TIMEOUT=8, r_rdy never asserted → rsp_valid with rsp_err=1 and rsp_data=0 after edge 9; the next pending requester is granted next.
- Simultaneous r_rdy and timeout expiry in the same cycle → data response with rsp_err=0.
- reset_n pulsed low mid-READ → all outputs 0 immediately, no rsp_valid; after release, arbitration restarts from requester 0.
